store_drain: RTL and testbench

- Sits directly downstream of the store queue and consumes its head entry.
- Holds one entry once it is valid and commited, writes it into the L1 data array over a req/gnt plus resp/nack handshake, and pulses a pop so the queue advances its read pointer.
- Retries nacked writes, and goes to a sticky error state when retries are exhausted.

---
 rtl/store_drain_if.sv | 35 +++
 rtl/store_drain.sv | 150 +++++++++++++++
 tb/tb_store_drain.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_drain_if.sv
// Head-of-store-queue and L1 write-port signals shared by store_drain and its neighbours.
// master = the drain engine, slave = the queue/cache side.
interface store_drain_if #(
    parameter int STQ_SZ_EXP = 3,
    parameter int ADDR_W     = 30
);
    logic                  head_valid;
    logic [STQ_SZ_EXP-1:0] head_idx;
    logic [ADDR_W-1:0]     head_addr;
    logic [3:0]            head_mask;
    logic [31:0]           head_data;
    logic                  head_pop;

    logic                  cache_req;
    logic [ADDR_W-1:0]     cache_addr;
    logic [3:0]            cache_mask;
    logic [31:0]           cache_data;
    logic                  cache_gnt;
    logic                  cache_resp_valid;
    logic                  cache_resp_nack;

    modport master (
        input  head_valid, head_idx, head_addr, head_mask, head_data,
        output head_pop,
        output cache_req, cache_addr, cache_mask, cache_data,
        input  cache_gnt, cache_resp_valid, cache_resp_nack
    );

    modport slave (
        output head_valid, head_idx, head_addr, head_mask, head_data,
        input  head_pop,
        input  cache_req, cache_addr, cache_mask, cache_data,
        output cache_gnt, cache_resp_valid, cache_resp_nack
    );
endinterface

// File: rtl/store_drain.sv
// Drains committed store-queue head entries into the L1 data array, retrying nacked writes.
// Optional linear backoff between retries: define STORE_DRAIN_BACKOFF_EN.
//
// Handshakes: cache_req is held with stable cache_addr/mask/data until a cycle with
// cache_gnt=1; the write is then outstanding until a cycle with cache_resp_valid=1
// (nack qualified by valid). head_pop is a one-cycle pulse; the queue advances on that edge.
module store_drain #(
    parameter int STQ_SZ_EXP = 3,
    parameter int ADDR_W     = 30,
    parameter int MAX_RETRY  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    store_drain_if.master         bus,
    output logic                  busy,
    output logic                  drained,
    output logic                  err,
    output logic [STQ_SZ_EXP-1:0] err_idx,
    output logic [2:0]            state_dbg
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        ERR     = 3'd3
`ifdef STORE_DRAIN_BACKOFF_EN
        , BACKOFF = 3'd4
`endif
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     hold_addr;
    logic [3:0]            hold_mask;
    logic [31:0]           hold_data;
    logic [STQ_SZ_EXP-1:0] hold_idx;
    logic [RW-1:0]         retry_cnt;
    logic [STQ_SZ_EXP-1:0] err_idx_q;
    logic                  do_latch;
    logic                  retry_inc;
    logic                  set_err;
    logic                  pop;
`ifdef STORE_DRAIN_BACKOFF_EN
    logic [RW-1:0]         bo_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_latch  = 1'b0;
        retry_inc = 1'b0;
        set_err   = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.head_valid) begin
                    if (bus.head_mask != 4'h0) begin
                        do_latch  = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        // Nothing to write: retire the entry without touching the cache.
                        pop = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.cache_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.cache_resp_valid) begin
                    if (!bus.cache_resp_nack) begin
                        pop       = 1'b1;
                        state_nxt = IDLE;
                    end else if (retry_cnt == RETRY_MAX) begin
                        set_err   = 1'b1;
                        state_nxt = ERR;
                    end else begin
                        retry_inc = 1'b1;
`ifdef STORE_DRAIN_BACKOFF_EN
                        state_nxt = BACKOFF;
`else
                        state_nxt = REQ;
`endif
                    end
                end
            end
`ifdef STORE_DRAIN_BACKOFF_EN
            BACKOFF: begin
                if (bo_cnt <= RW'(1)) state_nxt = REQ;
            end
`endif
            ERR: state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_mask <= '0;
            hold_data <= '0;
            hold_idx  <= '0;
            retry_cnt <= '0;
            err_idx_q <= '0;
        end else begin
            if (do_latch) begin
                hold_addr <= bus.head_addr;
                hold_mask <= bus.head_mask;
                hold_data <= bus.head_data;
                hold_idx  <= bus.head_idx;
                retry_cnt <= '0;
            end else if (retry_inc && retry_cnt != RETRY_MAX) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (set_err) err_idx_q <= hold_idx;
        end
    end

`ifdef STORE_DRAIN_BACKOFF_EN
    // The Nth nack waits N cycles: load the post-increment retry count, then count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bo_cnt <= '0;
        end else if (retry_inc) begin
            bo_cnt <= retry_cnt + 1'b1;
        end else if (state == BACKOFF && bo_cnt != '0) begin
            bo_cnt <= bo_cnt - 1'b1;
        end
    end
`endif

    // Gate with rst_n so a zero-mask head cannot pop while reset is held.
    assign bus.head_pop   = pop && rst_n;
    assign bus.cache_req  = (state == REQ);
    assign bus.cache_addr = hold_addr;
    assign bus.cache_mask = hold_mask;
    assign bus.cache_data = hold_data;

    assign busy      = (state != IDLE);
    assign drained   = (state == IDLE) && !bus.head_valid;
    assign err       = (state == ERR);
    assign err_idx   = err_idx_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_store_drain.sv
// Self-checking bench for store_drain: store-queue and cache responder models,
// a transaction-level reference model checked every cycle, and directed scenarios.
module tb_store_drain;
    localparam int STQ_SZ_EXP = 3;
    localparam int ADDR_W     = 30;
    localparam int MAX_RETRY  = 2;
    localparam int W          = ADDR_W + 36;
`ifdef STORE_DRAIN_BACKOFF_EN
    localparam int BO_EN = 1;
`else
    localparam int BO_EN = 0;
`endif

    typedef struct packed {
        logic [STQ_SZ_EXP-1:0] idx;
        logic [ADDR_W-1:0]     addr;
        logic [3:0]            mask;
        logic [31:0]           data;
    } store_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  busy, drained, err;
    logic [STQ_SZ_EXP-1:0] err_idx;
    logic [2:0]            state_dbg;

    store_drain_if #(.STQ_SZ_EXP(STQ_SZ_EXP), .ADDR_W(ADDR_W)) bus ();

    store_drain #(.STQ_SZ_EXP(STQ_SZ_EXP), .ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .drained   (drained),
        .err       (err),
        .err_idx   (err_idx),
        .state_dbg (state_dbg)
    );

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    store_t        stq[$];
    logic [W-1:0]  exp_q[$];
    bit            nack_plan[$];

    int gnt_pct = 100, spur_pct = 0, nack_pct = 0, hv_pct = 100, dly_min = 1, dly_max = 1;
    bit pending = 0, resp_real = 0, saw_pop = 0, saw_grant = 0, prev_req = 0;
    int resp_wait = 0, consec_nack = 0;
    logic [W-1:0] grant_payload = '0;

    int req_cycles = 0;
    int grant_cyc[$], pop_cyc[$], nack_cyc[$], req_rise[$];
    logic [STQ_SZ_EXP-1:0] pop_idx[$];
    logic [W-1:0] grant_log[$];

    // Reference model: one in-flight store, described by what has happened to it.
    bit                    m_have = 0, m_granted = 0, m_err = 0;
    int                    m_wait_left = 0, m_nacks = 0;
    logic [ADDR_W-1:0]     m_addr = '0;
    logic [3:0]            m_mask = '0;
    logic [31:0]           m_data = '0;
    logic [STQ_SZ_EXP-1:0] m_idx = '0, m_err_idx = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        m_have = 0; m_granted = 0; m_err = 0; m_wait_left = 0; m_nacks = 0;
        m_addr = '0; m_mask = '0; m_data = '0; m_idx = '0; m_err_idx = '0;
    endtask

    task automatic model_step();
        if (m_err) return;
        if (!m_have) begin
            if (bus.head_valid && bus.head_mask != 4'h0) begin
                m_have = 1; m_granted = 0; m_nacks = 0; m_wait_left = 0;
                m_addr = bus.head_addr; m_mask = bus.head_mask;
                m_data = bus.head_data; m_idx = bus.head_idx;
            end
        end else if (m_wait_left > 0) begin
            m_wait_left--;
        end else if (!m_granted) begin
            if (bus.cache_gnt) m_granted = 1;
        end else if (bus.cache_resp_valid) begin
            m_granted = 0;
            if (!bus.cache_resp_nack) begin
                m_have = 0;
            end else if (m_nacks == MAX_RETRY) begin
                m_err = 1;
                m_err_idx = m_idx;
            end else begin
                m_nacks++;
                m_wait_left = BO_EN * m_nacks;
            end
        end
    endtask

    // ---------------- drivers: store queue + cache responder ----------------
    always @(posedge clk) begin
        #1;
        resp_real = 0;
        if (!rst_n) begin
            pending = 0;
            consec_nack = 0;
        end else begin
            if (saw_pop && stq.size() > 0) void'(stq.pop_front());
            if (saw_grant) begin
                pending = 1;
                resp_wait = $urandom_range(dly_max, dly_min);
            end
        end
        saw_pop = 0;
        saw_grant = 0;

        if (stq.size() > 0 && $urandom_range(99) < hv_pct) begin
            bus.head_valid = 1'b1;
            bus.head_idx   = stq[0].idx;
            bus.head_addr  = stq[0].addr;
            bus.head_mask  = stq[0].mask;
            bus.head_data  = stq[0].data;
        end else begin
            bus.head_valid = 1'b0;
            bus.head_idx   = STQ_SZ_EXP'($urandom);
            bus.head_addr  = ADDR_W'($urandom);
            bus.head_mask  = 4'($urandom);
            bus.head_data  = $urandom;
        end

        bus.cache_gnt        = ($urandom_range(99) < gnt_pct);
        bus.cache_resp_valid = 1'b0;
        bus.cache_resp_nack  = 1'($urandom_range(1));
        if (pending) begin
            resp_wait--;
            if (resp_wait <= 0) begin
                pending = 0;
                resp_real = 1;
                bus.cache_resp_valid = 1'b1;
                if (nack_plan.size() > 0) bus.cache_resp_nack = nack_plan.pop_front();
                else bus.cache_resp_nack = (consec_nack < MAX_RETRY) && ($urandom_range(99) < nack_pct);
                consec_nack = bus.cache_resp_nack ? consec_nack + 1 : 0;
            end
        end else if ($urandom_range(99) < spur_pct) begin
            bus.cache_resp_valid = 1'b1;
        end
    end

    // ---------------- compare process / scoreboard ----------------
    always @(negedge clk) begin
        bit e_req, e_pop, e_busy;
        cyc++;
        if (!rst_n) model_reset();
        e_req  = m_have && !m_granted && m_wait_left == 0 && !m_err;
        e_busy = m_have || m_err;
        if (!rst_n || m_err)  e_pop = 0;
        else if (!m_have)     e_pop = bus.head_valid && bus.head_mask == 4'h0;
        else                  e_pop = m_granted && bus.cache_resp_valid && !bus.cache_resp_nack;

        check("head_pop",   W'(bus.head_pop),   W'(e_pop));
        check("cache_req",  W'(bus.cache_req),  W'(e_req));
        check("cache_addr", W'(bus.cache_addr), W'(m_addr));
        check("cache_mask", W'(bus.cache_mask), W'(m_mask));
        check("cache_data", W'(bus.cache_data), W'(m_data));
        check("busy",       W'(busy),           W'(e_busy));
        check("drained",    W'(drained),        W'(!e_busy && !bus.head_valid));
        check("err",        W'(err),            W'(m_err));
        check("err_idx",    W'(err_idx),        W'(m_err_idx));

        if (bus.cache_req) req_cycles++;
        if (bus.cache_req && !prev_req) req_rise.push_back(cyc);
        prev_req = bus.cache_req;

        if (rst_n) begin
            saw_pop   = bus.head_pop;
            saw_grant = bus.cache_req && bus.cache_gnt;
            if (saw_grant) begin
                grant_payload = {bus.cache_addr, bus.cache_mask, bus.cache_data};
                grant_cyc.push_back(cyc);
                grant_log.push_back(grant_payload);
            end
            if (bus.head_pop) begin
                pop_cyc.push_back(cyc);
                pop_idx.push_back(stq.size() > 0 ? stq[0].idx : '1);
            end
            if (resp_real && bus.cache_resp_nack) nack_cyc.push_back(cyc);
            if (resp_real && !bus.cache_resp_nack) begin
                if (exp_q.size() == 0) check("write_unexpected", grant_payload, '0);
                else check("write_payload", grant_payload, exp_q.pop_front());
            end
            model_step();
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic push_store(input logic [STQ_SZ_EXP-1:0] idx, input logic [ADDR_W-1:0] a,
                              input logic [3:0] m, input logic [31:0] d);
        store_t s;
        s.idx = idx; s.addr = a; s.mask = m; s.data = d;
        stq.push_back(s);
        if (m != 4'h0) exp_q.push_back({a, m, d});
    endtask

    task automatic clear_logs();
        req_cycles = 0;
        grant_cyc.delete(); pop_cyc.delete(); nack_cyc.delete();
        req_rise.delete(); pop_idx.delete(); grant_log.delete();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((stq.size() > 0 || pending || m_have) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) timeout_fail(name);
        repeat (3) @(posedge clk);
        settle();
    endtask

    task automatic directed_mode();
        gnt_pct = 100; spur_pct = 0; nack_pct = 0; hv_pct = 100; dly_min = 1; dly_max = 1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [3:0] rm;
        directed_mode();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        settle();
        check("reset_drained", W'(drained), W'(1));
        check("reset_busy",    W'(busy),    W'(0));
        check("reset_req",     W'(bus.cache_req), W'(0));
        check("reset_err",     W'(err),     W'(0));

        // Single store
        clear_logs();
        push_store(3'd0, 30'h10, 4'hF, 32'hDEADBEEF);
        wait_idle("single", 200);
        check("single_req_cycles", W'(req_cycles), W'(1));
        check("single_pops", W'(pop_cyc.size()), W'(1));
        if (pop_cyc.size() > 0 && grant_cyc.size() > 0)
            check("single_pop_after_gnt", W'(pop_cyc[0] - grant_cyc[0]), W'(1));
        if (grant_log.size() > 0)
            check("single_payload", grant_log[0], {30'h10, 4'hF, 32'hDEADBEEF});
        check("single_drained", W'(drained), W'(1));

        // Back-to-back: four stores, pops every 3 cycles in slot order
        clear_logs();
        for (int i = 0; i < 4; i++)
            push_store(STQ_SZ_EXP'(i + 1), ADDR_W'($urandom), 4'($urandom_range(15, 1)), $urandom);
        wait_idle("b2b", 400);
        check("b2b_pops", W'(pop_cyc.size()), W'(4));
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("b2b_spacing", W'(pop_cyc[i] - pop_cyc[i-1]), W'(3));
            for (int i = 0; i < 4; i++) check("b2b_order", W'(pop_idx[i]), W'(i + 1));
        end

        // Zero mask: retired from IDLE without a cache access
        clear_logs();
        push_store(3'd6, ADDR_W'($urandom), 4'h0, $urandom);
        wait_idle("zero_mask", 100);
        check("zero_pops", W'(pop_cyc.size()), W'(1));
        check("zero_req_cycles", W'(req_cycles), W'(0));
        if (pop_idx.size() > 0) check("zero_idx", W'(pop_idx[0]), W'(6));

        // Nack twice then ack
        clear_logs();
        nack_plan = '{1'b1, 1'b1, 1'b0};
        push_store(3'd2, 30'h2A0, 4'h3, 32'h12345678);
        wait_idle("nack_retry", 300);
        check("nack_grants", W'(grant_cyc.size()), W'(3));
        check("nack_pops",   W'(pop_cyc.size()), W'(1));
        if (nack_cyc.size() == 2 && req_rise.size() == 3) begin
            check("nack_gap1", W'(req_rise[1] - nack_cyc[0] - 1), W'(BO_EN * 1));
            check("nack_gap2", W'(req_rise[2] - nack_cyc[1] - 1), W'(BO_EN * 2));
        end else begin
            check("nack_events", W'(nack_cyc.size()), W'(2));
        end

        // Randomized traffic
        gnt_pct = 60; spur_pct = 10; nack_pct = 20; hv_pct = 85; dly_min = 1; dly_max = 3;
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(3)) @(posedge clk);
            rm = ($urandom_range(9) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            push_store(STQ_SZ_EXP'(i), ADDR_W'($urandom), rm, $urandom);
        end
        wait_idle("random", 20000);
        check("random_all_written", W'(exp_q.size()), W'(0));
        directed_mode();

        // Exhaustion: every response nacked
        clear_logs();
        nack_plan = '{1'b1, 1'b1, 1'b1};
        push_store(3'd5, 30'h1234, 4'h9, 32'hA5A5A5A5);
        n = 0;
        while (!m_err && n < 200) begin @(posedge clk); n++; end
        if (n >= 200) timeout_fail("exhaust_wait");
        repeat (5) @(posedge clk);
        settle();
        check("exh_grants",  W'(grant_cyc.size()), W'(3));
        check("exh_err",     W'(err), W'(1));
        check("exh_err_idx", W'(err_idx), W'(5));
        check("exh_pops",    W'(pop_cyc.size()), W'(0));
        check("exh_busy",    W'(busy), W'(1));
        check("exh_drained", W'(drained), W'(0));
        stq.delete(); exp_q.delete(); nack_plan.delete();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        settle();
        check("exh_reset_err", W'(err), W'(0));

        // Reset while waiting for a response
        clear_logs();
        dly_min = 6; dly_max = 6;
        push_store(3'd3, 30'h3FF0, 4'hC, 32'hCAFEF00D);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!(pending && m_granted) && n < 100);
        if (n >= 100) timeout_fail("reset_wait");
        check("rst_pre_busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", W'(busy), W'(0));
        check("rst_async_req",  W'(bus.cache_req), W'(0));
        check("rst_async_pop",  W'(bus.head_pop), W'(0));
        check("rst_async_drained", W'(drained), W'(0));
        check("rst_async_addr", W'(bus.cache_addr), W'(0));
        clear_logs();
        dly_min = 1; dly_max = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle("rst_rewrite", 200);
        check("rst_grants", W'(grant_cyc.size()), W'(1));
        check("rst_pops",   W'(pop_cyc.size()), W'(1));
        if (pop_idx.size() > 0) check("rst_idx", W'(pop_idx[0]), W'(3));
        check("rst_written", W'(exp_q.size()), W'(0));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
